// File: rtl/countdown_pkg.sv
// Shared types and default constants for the countdown timer controller.
package countdown_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default BCD presets {tens, ones}.
  localparam logic [7:0] PRESET0_DEF = 8'h24;
  localparam logic [7:0] PRESET1_DEF = 8'h30;

endpackage

// File: rtl/countdown_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, level debounce and a one-cycle
// pulse on each accepted press (debounced 1->0 transition).
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 1_000_000
) (
  input  logic clkin,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  // Count only reaches DEBOUNCE-1 before the level flips.
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Two-flop synchronizer; idle (released) level is 1.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n};
  end

  // Accept a new level only after it has differed for DEBOUNCE straight cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: conditions the buttons, generates the step
// tick, and runs the IDLE/RUN/PAUSE/DONE machine driving the BCD datapath.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DEBOUNCE  = 1_000_000,
  parameter int unsigned FLASH_DIV = 25_000_000,
  parameter logic [7:0]  PRESET0   = PRESET0_DEF,
  parameter logic [7:0]  PRESET1   = PRESET1_DEF
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       start_n,
  input  logic       clear_n,
  input  logic       preset_sel,
  input  logic       count_zero,
  output logic       load,
  output logic [7:0] load_value,
  output logic       dec_en,
  output logic       running,
  output logic       expired,
  output logic       blank
);

  // One prescaler serves as step divider in RUN and flash timer in DONE.
  localparam int unsigned MAXDIV = (TICK_DIV > FLASH_DIV) ? TICK_DIV : FLASH_DIV;
  localparam int unsigned PW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FLASH_LAST = PW'(FLASH_DIV - 1);

  logic          start_p, clear_p;
  logic [1:0]    psel_q;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          blank_q, blank_d;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_start_db (
    .clkin (clkin),
    .reset (reset),
    .btn_n (start_n),
    .press (start_p)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_clear_db (
    .clkin (clkin),
    .reset (reset),
    .btn_n (clear_n),
    .press (clear_p)
  );

  // Preset switch synchronizer.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) psel_q <= 2'b00;
    else        psel_q <= {psel_q[0], preset_sel};
  end

  assign load_value = psel_q[1] ? PRESET1 : PRESET0;

  // Next-state, prescaler and flash logic; clear overrides everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blank_d = blank_q;
    dec_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // A tick takes priority over a start press in the same cycle.
        if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (count_zero) begin
            state_d = DONE;
            blank_d = 1'b0;
          end else begin
            dec_en = 1'b1;
          end
        end else if (start_p) begin
          state_d = PAUSE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        if (start_p) state_d = RUN;
      end
      DONE: begin
        if (presc_q == FLASH_LAST) begin
          presc_d = '0;
          blank_d = ~blank_q;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (start_p) begin
          state_d = IDLE;
          presc_d = '0;
          blank_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_p) begin
      state_d = IDLE;
      presc_d = '0;
      blank_d = 1'b0;
    end
  end

  // State, prescaler and blank registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
    end
  end

  assign load    = (state_q == IDLE);
  assign running = (state_q == RUN);
  assign expired = (state_q == DONE);
  assign blank   = blank_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with small dividers.
module tb_countdown_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       start_n, clear_n, preset_sel, count_zero;
  logic       load, dec_en, running, expired, blank;
  logic [7:0] load_value;

  int pass_cnt = 0;
  int total_cnt = 0;

  countdown_ctrl #(
    .TICK_DIV (4),
    .DEBOUNCE (2),
    .FLASH_DIV(3),
    .PRESET0  (8'h24),
    .PRESET1  (8'h30)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .start_n    (start_n),
    .clear_n    (clear_n),
    .preset_sel (preset_sel),
    .count_zero (count_zero),
    .load       (load),
    .load_value (load_value),
    .dec_en     (dec_en),
    .running    (running),
    .expired    (expired),
    .blank      (blank)
  );

  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start_n = 1'b1; clear_n = 1'b1; preset_sel = 1'b0; count_zero = 1'b0;
    step(3);
    total_cnt++; if (load !== 1'b1) $display("FAIL rst_load got=%b exp=1", load); else pass_cnt++;
    total_cnt++; if (load_value !== 8'h24) $display("FAIL rst_value got=%h exp=24", load_value); else pass_cnt++;
    total_cnt++; if (dec_en !== 1'b0) $display("FAIL rst_dec got=%b exp=0", dec_en); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL rst_running got=%b exp=0", running); else pass_cnt++;
    total_cnt++; if (expired !== 1'b0) $display("FAIL rst_expired got=%b exp=0", expired); else pass_cnt++;
    total_cnt++; if (blank !== 1'b0) $display("FAIL rst_blank got=%b exp=0", blank); else pass_cnt++;
    reset = 1'b1;
    step(1);
    total_cnt++; if (load !== 1'b1) $display("FAIL post_rst_load got=%b exp=1", load); else pass_cnt++;
    total_cnt++; if (load_value !== 8'h24) $display("FAIL post_rst_value got=%h exp=24", load_value); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_preset;
    preset_sel = 1'b1;
    step(1);
    total_cnt++; if (load_value !== 8'h24) $display("FAIL preset_sync1 got=%h exp=24", load_value); else pass_cnt++;
    step(1);
    total_cnt++; if (load_value !== 8'h30) $display("FAIL preset_sync2 got=%h exp=30", load_value); else pass_cnt++;
    preset_sel = 1'b0;
    step(2);
    total_cnt++; if (load_value !== 8'h24) $display("FAIL preset_back got=%h exp=24", load_value); else pass_cnt++;
    $display("test_preset done");
  endtask

  task automatic test_run_ticks;
    start_n = 1'b0;
    step(4);
    total_cnt++; if (running !== 1'b0) $display("FAIL start_early got=%b exp=0", running); else pass_cnt++;
    step(1);
    // Now in RUN cycle 1 (prescaler 0); ticks in cycles 4, 8, 12.
    for (int c = 1; c <= 13; c++) begin
      if (c == 2) start_n = 1'b1;
      total_cnt++; if (running !== 1'b1) $display("FAIL run_running cyc=%0d got=%b exp=1", c, running); else pass_cnt++;
      total_cnt++; if (dec_en !== ((c % 4) == 0)) $display("FAIL run_dec cyc=%0d got=%b exp=%b", c, dec_en, (c % 4) == 0); else pass_cnt++;
      step(1);
    end
    $display("test_run_ticks done");
  endtask

  task automatic test_pause;
    // In RUN cycle 14 (prescaler 1); press so the pulse lands on prescaler 2.
    step(1);
    start_n = 1'b0;
    step(4);
    total_cnt++; if (running !== 1'b1) $display("FAIL pause_pulse_cycle got=%b exp=1", running); else pass_cnt++;
    step(1);
    total_cnt++; if (running !== 1'b0 || load !== 1'b0 || expired !== 1'b0)
      $display("FAIL pause_enter run/load/exp got=%b%b%b exp=000", running, load, expired); else pass_cnt++;
    step(1);
    start_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total_cnt++; if (dec_en !== 1'b0 || running !== 1'b0) $display("FAIL pause_hold i=%0d dec=%b run=%b exp=0,0", i, dec_en, running); else pass_cnt++;
      step(1);
    end
    start_n = 1'b0;
    step(5);
    total_cnt++; if (running !== 1'b1 || dec_en !== 1'b0) $display("FAIL resume_c1 run=%b dec=%b exp=1,0", running, dec_en); else pass_cnt++;
    step(1);
    total_cnt++; if (dec_en !== 1'b1) $display("FAIL resume_c2_dec got=%b exp=1", dec_en); else pass_cnt++;
    start_n = 1'b1;
    $display("test_pause done");
  endtask

  task automatic test_done;
    step(1);
    count_zero = 1'b1;
    step(3);
    total_cnt++; if (dec_en !== 1'b0) $display("FAIL zero_tick_dec got=%b exp=0", dec_en); else pass_cnt++;
    total_cnt++; if (running !== 1'b1) $display("FAIL zero_tick_running got=%b exp=1", running); else pass_cnt++;
    step(1);
    for (int d = 1; d <= 9; d++) begin
      total_cnt++; if (expired !== 1'b1 || running !== 1'b0) $display("FAIL done_state d=%0d exp_o=%b run=%b exp=1,0", d, expired, running); else pass_cnt++;
      total_cnt++; if (blank !== (((d - 1) / 3) % 2 == 1)) $display("FAIL done_blank d=%0d got=%b exp=%b", d, blank, ((d - 1) / 3) % 2 == 1); else pass_cnt++;
      step(1);
    end
    start_n = 1'b0;
    step(4);
    total_cnt++; if (expired !== 1'b1) $display("FAIL done_before_exit got=%b exp=1", expired); else pass_cnt++;
    step(1);
    total_cnt++; if (load !== 1'b1 || blank !== 1'b0 || expired !== 1'b0)
      $display("FAIL done_exit load/blank/exp got=%b%b%b exp=100", load, blank, expired); else pass_cnt++;
    step(1);
    start_n = 1'b1;
    count_zero = 1'b0;
    step(6);
    $display("test_done done");
  endtask

  task automatic test_back_to_back;
    start_n = 1'b0;
    step(5);
    total_cnt++; if (running !== 1'b1) $display("FAIL b2b_enter_run got=%b exp=1", running); else pass_cnt++;
    step(1);
    start_n = 1'b1;
    step(6);
    start_n = 1'b0;
    clear_n = 1'b0;
    step(4);
    total_cnt++; if (running !== 1'b1) $display("FAIL b2b_pulse_cycle got=%b exp=1", running); else pass_cnt++;
    step(1);
    total_cnt++; if (running !== 1'b0 || load !== 1'b1) $display("FAIL b2b_clear_wins run=%b load=%b exp=0,1", running, load); else pass_cnt++;
    step(1);
    start_n = 1'b1;
    clear_n = 1'b1;
    step(6);
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_run;
    preset_sel = 1'b1;
    start_n = 1'b0;
    step(5);
    total_cnt++; if (running !== 1'b1) $display("FAIL mid_enter_run got=%b exp=1", running); else pass_cnt++;
    step(1);
    start_n = 1'b1;
    step(2);
    reset = 1'b0;
    #1;
    total_cnt++; if (running !== 1'b0 || load !== 1'b1) $display("FAIL async_rst run=%b load=%b exp=0,1", running, load); else pass_cnt++;
    total_cnt++; if (load_value !== 8'h24) $display("FAIL async_rst_value got=%h exp=24", load_value); else pass_cnt++;
    total_cnt++; if (dec_en !== 1'b0 || expired !== 1'b0 || blank !== 1'b0)
      $display("FAIL async_rst dec/exp/blank got=%b%b%b exp=000", dec_en, expired, blank); else pass_cnt++;
    preset_sel = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    total_cnt++; if (load !== 1'b1 || running !== 1'b0) $display("FAIL post_mid_rst load=%b run=%b exp=1,0", load, running); else pass_cnt++;
    $display("test_reset_mid_run done");
  endtask

  task automatic test_glitch;
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      total_cnt++; if (running !== 1'b0 || load !== 1'b1) $display("FAIL glitch i=%0d run=%b load=%b exp=0,1", i, running, load); else pass_cnt++;
    end
    $display("test_glitch done");
  endtask

  initial begin
    test_reset();
    test_preset();
    test_run_ticks();
    test_pause();
    test_done();
    test_back_to_back();
    test_reset_mid_run();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
